// File: rtl/vga_frame_reader_pkg.sv
// Shared memory and frame-buffer constants for the VGA read path.
// Latency: none (constants only).
// Backpressure: none (constants only).
package vga_frame_reader_pkg;

  localparam int LOG_MEM         = 36;      // ZBT word width, two packed pixels
  localparam int LOG_ADDR        = 19;      // ZBT word-address width
  localparam int VGA_FRAME_WORDS = 153600;  // 640x480 pixels, two per word
  localparam int VGA_BUF_STRIDE  = 262144;  // base address of frame buffer 1
  localparam int ZBT_RD_LAT      = 2;       // cycles from read strobe to data

endpackage

// File: rtl/vga_frame_reader_frame_buf_sel.sv
// Display/write frame-buffer selector; swaps on frame boundary after writer completes a frame.
// Latency: disp_buf changes the cycle after the frame_flag that commits a pending swap.
// Backpressure: none; a second swap_req before the swap commits is flagged on swap_ovr.
// Built with swap logic only when VGA_DOUBLE_BUFFER_EN is defined; otherwise constant buffer 0.
module frame_buf_sel (
  input  logic clock,
  input  logic reset,
  input  logic frame_flag,
  input  logic swap_req,
  output logic disp_buf,
  output logic swap_ovr
);

`ifdef VGA_DOUBLE_BUFFER_EN
  logic swap_pend_q, swap_pend_d;
  logic disp_buf_q, disp_buf_d;

  // Next-state: latch writer completion, commit it at the next frame boundary
  always_comb begin
    swap_pend_d = swap_pend_q;
    disp_buf_d  = disp_buf_q;
    if (swap_req) begin
      swap_pend_d = 1'b1;
    end
    // A completion arriving in the boundary cycle itself is committed immediately
    if (frame_flag && (swap_pend_q || swap_req)) begin
      disp_buf_d  = ~disp_buf_q;
      swap_pend_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      swap_pend_q <= 1'b0;
      disp_buf_q  <= 1'b0;
    end else begin
      swap_pend_q <= swap_pend_d;
      disp_buf_q  <= disp_buf_d;
    end
  end

  assign disp_buf = disp_buf_q;
  // Writer finished another frame before the previous one was ever displayed
  assign swap_ovr = swap_req & swap_pend_q & ~reset;
`else
  logic unused_inputs;
  assign unused_inputs = ^{clock, reset, frame_flag, swap_req};
  assign disp_buf      = 1'b0;
  assign swap_ovr      = 1'b0;
`endif

endmodule

// File: rtl/vga_frame_reader.sv
// VGA memory read port: turns vga_flag word requests into ZBT reads at sequential addresses.
// Latency: vga_pixel/done_vga appear ZBT_RD_LAT (2) cycles after the request; one request per cycle.
// Backpressure: none; VGA reads are always granted, requests during frame_flag are dropped.
// Optional double buffering is enabled by defining VGA_DOUBLE_BUFFER_EN.
module vga_frame_reader
  import vga_frame_reader_pkg::*;
#(
  parameter int LOG_MEM     = vga_frame_reader_pkg::LOG_MEM,
  parameter int LOG_ADDR    = vga_frame_reader_pkg::LOG_ADDR,
  parameter int FRAME_WORDS = VGA_FRAME_WORDS,
  parameter int BUF_STRIDE  = VGA_BUF_STRIDE
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                frame_flag,
  input  logic                vga_flag,
  output logic [LOG_MEM-1:0]  vga_pixel,
  output logic                done_vga,
  input  logic                swap_req,
  output logic                write_buf,
  output logic                disp_buf,
  output logic                mem_req,
  output logic [LOG_ADDR-1:0] mem_addr,
  input  logic [LOG_MEM-1:0]  mem_rdata,
  output logic                overrun
);

  localparam logic [LOG_ADDR-1:0] LAST_WORD = LOG_ADDR'(FRAME_WORDS - 1);
  localparam logic [LOG_ADDR-1:0] BUF1_BASE = LOG_ADDR'(BUF_STRIDE);

  logic [LOG_ADDR-1:0]   wcnt_q, wcnt_d;
  logic [ZBT_RD_LAT-1:0] v_q, v_d;
  logic [LOG_MEM-1:0]    hold_q, hold_d;
  logic                  overrun_q, overrun_d;
  logic                  sel_disp;
  logic                  swap_ovr;
  logic                  wrap;
  logic                  ret_vld;

  frame_buf_sel u_frame_buf_sel (
    .clock      (clock),
    .reset      (reset),
    .frame_flag (frame_flag),
    .swap_req   (swap_req),
    .disp_buf   (sel_disp),
    .swap_ovr   (swap_ovr)
  );

  // A request coinciding with the frame boundary is dropped so the new frame starts clean
  assign mem_req  = vga_flag & ~frame_flag & ~reset;
  assign wrap     = mem_req && (wcnt_q == LAST_WORD);
  assign ret_vld  = v_q[ZBT_RD_LAT-1];

  assign disp_buf = sel_disp & ~reset;
`ifdef VGA_DOUBLE_BUFFER_EN
  assign write_buf = ~disp_buf;
`else
  assign write_buf = 1'b0;
`endif

  // Outputs are forced to their idle values while reset is held
  assign mem_addr  = reset ? '0 : ((disp_buf ? BUF1_BASE : '0) + wcnt_q);
  assign done_vga  = ret_vld & ~reset;
  assign vga_pixel = reset ? '0 : (ret_vld ? mem_rdata : hold_q);
  assign overrun   = overrun_q;

  // Next-state: word counter, return-valid shift register, held pixel, sticky error
  always_comb begin
    wcnt_d    = wcnt_q;
    v_d       = (v_q << 1) | ZBT_RD_LAT'(mem_req);
    hold_d    = ret_vld ? mem_rdata : hold_q;
    overrun_d = overrun_q | wrap | swap_ovr;
    if (frame_flag) begin
      wcnt_d = '0;
    end else if (mem_req) begin
      // Over-reading the frame wraps to the start and is reported via overrun
      wcnt_d = wrap ? '0 : wcnt_q + 1'b1;
    end
  end

  // State registers; reset also discards any read returns still in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt_q    <= '0;
      v_q       <= '0;
      hold_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      v_q       <= v_d;
      hold_q    <= hold_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed self-checking bench for vga_frame_reader with a 2-cycle ZBT model returning data = address.
// Uses a shortened frame so the wrap case runs in a few hundred cycles.
// Swap expectations follow whether VGA_DOUBLE_BUFFER_EN is defined.
module tb_vga_frame_reader;

  localparam int LM     = 36;
  localparam int LA     = 19;
  localparam int FW     = 160;
  localparam int STRIDE = 262144;
`ifdef VGA_DOUBLE_BUFFER_EN
  localparam logic DB = 1'b1;
`else
  localparam logic DB = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          frame_flag;
  logic          vga_flag;
  logic [LM-1:0] vga_pixel;
  logic          done_vga;
  logic          swap_req;
  logic          write_buf;
  logic          disp_buf;
  logic          mem_req;
  logic [LA-1:0] mem_addr;
  logic [LM-1:0] mem_rdata;
  logic          overrun;

  logic [LA-1:0] a1, a2;
  int checks = 0;
  int errors = 0;

  vga_frame_reader #(
    .LOG_MEM     (LM),
    .LOG_ADDR    (LA),
    .FRAME_WORDS (FW),
    .BUF_STRIDE  (STRIDE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .frame_flag (frame_flag),
    .vga_flag   (vga_flag),
    .vga_pixel  (vga_pixel),
    .done_vga   (done_vga),
    .swap_req   (swap_req),
    .write_buf  (write_buf),
    .disp_buf   (disp_buf),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ZBT model: read data equals the address presented two cycles earlier
  always @(posedge clock) begin
    a1 <= mem_addr;
    a2 <= a1;
  end
  assign mem_rdata = LM'(a2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; frame_flag = 1'b0; vga_flag = 1'b1; swap_req = 1'b0;

    // Reset state, with a request held high to prove it is masked
    mid();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done", done_vga, 0);
    chk("rst_pixel", vga_pixel, 0);
    chk("rst_write_buf", write_buf, DB);
    chk("rst_disp_buf", disp_buf, 0);
    chk("rst_overrun", overrun, 0);
    tick(); tick();

    // Three back-to-back requests
    reset = 1'b0;
    mid(); chk("c0_mem_req", mem_req, 1); chk("c0_addr", mem_addr, 0); chk("c0_done", done_vga, 0); tick();
    mid(); chk("c1_addr", mem_addr, 1); chk("c1_done", done_vga, 0); tick();
    mid(); chk("c2_addr", mem_addr, 2); chk("c2_done", done_vga, 1); chk("c2_pixel", vga_pixel, 0); tick();
    vga_flag = 1'b0;
    mid(); chk("c3_mem_req", mem_req, 0); chk("c3_done", done_vga, 1); chk("c3_pixel", vga_pixel, 1); tick();
    mid(); chk("c4_done", done_vga, 1); chk("c4_pixel", vga_pixel, 2); tick();
    mid(); chk("c5_done", done_vga, 0); chk("c5_pixel_hold", vga_pixel, 2); tick();

    // Advance to wcnt=10, then frame_flag together with vga_flag
    vga_flag = 1'b1;
    for (int i = 3; i < 10; i++) begin
      mid(); chk("seq_addr", mem_addr, i); tick();
    end
    frame_flag = 1'b1;
    mid(); chk("ff_mem_req", mem_req, 0); chk("ff_inflight_done", done_vga, 1); chk("ff_inflight_pixel", vga_pixel, 8); tick();
    frame_flag = 1'b0; vga_flag = 1'b0;
    mid(); chk("ff1_done", done_vga, 1); chk("ff1_pixel", vga_pixel, 9); tick();
    mid(); chk("ff2_dropped_done", done_vga, 0); chk("ff2_pixel_hold", vga_pixel, 9); tick();
    vga_flag = 1'b1;
    mid(); chk("ff_rewind_addr", mem_addr, 0); tick();
    vga_flag = 1'b0;
    tick(); tick();

    // Wrap past the last word of the frame
    frame_flag = 1'b1; tick(); frame_flag = 1'b0;
    vga_flag = 1'b1;
    for (int i = 0; i < FW; i++) begin
      mid();
      if (i == FW - 1) begin
        chk("wrap_last_addr", mem_addr, FW - 1);
        chk("wrap_pre_overrun", overrun, 0);
      end
      tick();
    end
    mid(); chk("wrap_next_addr", mem_addr, 0); chk("wrap_overrun", overrun, 1); tick();
    vga_flag = 1'b0;
    tick(); tick(); tick();
    mid(); chk("overrun_sticky", overrun, 1); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    mid(); chk("overrun_cleared", overrun, 0); tick();

    // Single swap committed at the next frame boundary
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    frame_flag = 1'b1; tick(); frame_flag = 1'b0;
    vga_flag = 1'b1;
    mid();
    chk("swap_disp_buf", disp_buf, DB);
    chk("swap_write_buf", write_buf, 0);
    chk("swap_addr", mem_addr, DB ? STRIDE : 0);
    chk("swap_no_overrun", overrun, 0);
    tick();
    vga_flag = 1'b0;

    // Two completions before one boundary: overrun, and only one toggle
    swap_req = 1'b1; tick(); swap_req = 1'b0; tick();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    mid(); chk("dswap_overrun", overrun, DB); tick();
    frame_flag = 1'b1; tick(); frame_flag = 1'b0;
    mid(); chk("dswap_disp_after1", disp_buf, 0); chk("dswap_write_after1", write_buf, DB); tick();
    frame_flag = 1'b1; tick(); frame_flag = 1'b0;
    mid(); chk("dswap_disp_after2", disp_buf, 0); tick();

    // Reset one cycle after a request discards its return
    reset = 1'b1; tick(); reset = 1'b0;
    vga_flag = 1'b1; tick(); tick();
    vga_flag = 1'b0; tick();
    mid(); chk("pre_rst_done", done_vga, 1); chk("pre_rst_pixel", vga_pixel, 1); tick();
    vga_flag = 1'b1;
    mid(); chk("pre_rst_addr", mem_addr, 2); tick();
    vga_flag = 1'b0; reset = 1'b1;
    mid(); chk("midrst_done", done_vga, 0); chk("midrst_pixel", vga_pixel, 0); tick();
    reset = 1'b0;
    mid(); chk("postrst_done", done_vga, 0); chk("postrst_pixel", vga_pixel, 0); tick();
    mid(); chk("postrst2_done", done_vga, 0); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
